// File: rtl/fetch_queue_pkg.sv
// fetch_pkg: shared fetch-stage types and constants.
package fetch_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam logic [5:0] HALT_OP = 6'b111111;
  typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_t;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_instr_fifo.sv
// instr_fifo: show-ahead FIFO with registered head and synchronous flush.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic             o_valid,
  output logic [AW:0]      o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  always_ff @(posedge clk)
    if (rst_n && !i_flush && i_push) r_mem[r_wptr] <= i_din;
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
    end
  end
  assign o_head  = r_mem[r_rptr];
  assign o_valid = r_count != '0;
  assign o_count = r_count;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC register, halt FSM and redirect arbitration in front of a show-ahead fetch FIFO.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int         ADDR_W  = ADDR_W_DEF,
  parameter int         QDEPTH  = 4,
  parameter logic [5:0] HALT_OP = fetch_pkg::HALT_OP,
  localparam int CW = $clog2(QDEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_pc,
  input  logic [31:0]       mem_instr,
  input  logic              mem_isdone,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              issue_valid,
  output logic [31:0]       issue_instr,
  output logic [ADDR_W-1:0] issue_pc,
  input  logic              issue_ready,
  output logic [CW-1:0]     q_count,
  output logic              halted
);
  logic [ADDR_W-1:0]    r_pc;
  state_t               r_state;
  logic                 w_halt;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_valid;
  logic                 w_drained;
  logic [CW-1:0]        w_count;
  logic [ADDR_W+31:0]   w_head;
  instr_fifo #(.DEPTH(QDEPTH), .WIDTH(ADDR_W + 32)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({r_pc, mem_instr}),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_count (w_count)
  );
  always_comb begin
    w_halt    = mem_isdone | (mem_instr[31:26] == HALT_OP);
    w_pop     = w_valid & issue_ready & !redirect_valid;
    w_push    = (r_state == FETCH) & !w_halt & !redirect_valid & ((w_count < CW'(QDEPTH)) | w_pop);
    w_drained = (w_count == '0) | ((w_count == CW'(1)) & w_pop);
  end
  // Redirect overrides everything, including a pending halt or a terminal HALTED state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_state <= FETCH;
    end else if (redirect_valid) begin
      r_pc    <= redirect_pc;
      r_state <= FETCH;
    end else begin
      if (w_push) r_pc <= r_pc + 1'b1;
      r_state <= (r_state == FETCH && w_halt) ? DRAIN :
                 (r_state == DRAIN && w_drained) ? HALTED : r_state;
    end
  end
  assign mem_pc                = r_pc;
  assign issue_valid           = w_valid;
  assign {issue_pc, issue_instr} = w_head;
  assign q_count               = w_count;
  assign halted                = r_state == HALTED;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random scenarios checked against a behavioural queue model.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic        issue_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] halt_pc = 32'h8000_0000;
  logic [31:0] mem_pc, mem_instr, issue_instr, issue_pc;
  logic        mem_isdone, issue_valid, halted;
  logic [2:0]  q_count;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] m_q[$];
  logic [31:0] m_pc = '0;
  int          m_st = 0;

  always #5 clk = ~clk;

  assign mem_instr  = (mem_pc == halt_pc) ? {6'h3F, mem_pc[25:0]} : {6'h01, mem_pc[25:0] ^ 26'h2AAAAAA};
  assign mem_isdone = mem_instr[31:26] == 6'h3F;

  fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .mem_pc(mem_pc), .mem_instr(mem_instr), .mem_isdone(mem_isdone),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .issue_valid(issue_valid),
    .issue_instr(issue_instr), .issue_pc(issue_pc), .issue_ready(issue_ready),
    .q_count(q_count), .halted(halted)
  );

  function automatic logic [31:0] instr_at(logic [31:0] pc);
    return (pc == halt_pc) ? {6'h3F, pc[25:0]} : {6'h01, pc[25:0] ^ 26'h2AAAAAA};
  endfunction

  // Advances one clock; the model queue doubles as the scoreboard of expected issues.
  task automatic cyc();
    int n;
    logic pop, push, hlt;
    n = m_q.size();
    pop = n != 0 && issue_ready && !redirect_valid;
    hlt = m_pc == halt_pc;
    push = m_st == 0 && !hlt && !redirect_valid && (n < 4 || pop);
    if (!rst_n) begin
      m_q.delete(); m_pc = '0; m_st = 0;
    end else if (redirect_valid) begin
      m_q.delete(); m_pc = redirect_pc; m_st = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin m_q.push_back({m_pc, instr_at(m_pc)}); m_pc = m_pc + 1; end
      if (m_st == 0 && hlt) m_st = 1;
      else if (m_st == 1 && m_q.size() == 0) m_st = 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; issue_ready = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    checks++; if (mem_pc !== 32'h0) begin errors++; $display("FAIL reset_mem_pc got %0h exp 0", mem_pc); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_q_count got %0d exp 0", q_count); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got %b exp 0", issue_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    issue_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++; if (mem_pc !== 32'(i + 1)) begin errors++; $display("FAIL stream_mem_pc got %0h exp %0h", mem_pc, i + 1); end
      checks++; if (q_count > 3'd1) begin errors++; $display("FAIL stream_q_count got %0d exp <=1", q_count); end
      checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'(i)) begin errors++; $display("FAIL stream_issue_pc got v%b %0h exp v1 %0h", issue_valid, issue_pc, i); end
      checks++; if (issue_instr !== instr_at(32'(i))) begin errors++; $display("FAIL stream_issue_instr got %0h exp %0h", issue_instr, instr_at(32'(i))); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 10; i++) cyc();
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL bp_full_count got %0d exp 4", q_count); end
    checks++; if (mem_pc !== 32'h4) begin errors++; $display("FAIL bp_frozen_pc got %0h exp 4", mem_pc); end
    checks++; if (issue_pc !== 32'h0) begin errors++; $display("FAIL bp_head got %0h exp 0", issue_pc); end
    issue_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      checks++; if (issue_pc !== 32'(k + 1)) begin errors++; $display("FAIL bp_order got %0h exp %0h", issue_pc, k + 1); end
      checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL bp_pushpop_count got %0d exp 4", q_count); end
      checks++; if (mem_pc !== 32'(k + 5)) begin errors++; $display("FAIL bp_resume_pc got %0h exp %0h", mem_pc, k + 5); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) cyc();
    checks++; if (q_count !== 3'd3) begin errors++; $display("FAIL redir_pre_count got %0d exp 3", q_count); end
    redirect_valid = 1'b1; redirect_pc = 32'h40; issue_ready = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL redir_count got %0d exp 0", q_count); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b exp 0", issue_valid); end
    checks++; if (mem_pc !== 32'h40) begin errors++; $display("FAIL redir_mem_pc got %0h exp 40", mem_pc); end
    cyc();
    checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h40) begin errors++; $display("FAIL redir_first_issue got v%b %0h exp v1 40", issue_valid, issue_pc); end
  endtask

  task automatic test_halt();
    do_reset();
    halt_pc = 32'h7; issue_ready = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    issue_ready = 1'b0; cyc();
    issue_ready = 1'b1; cyc();
    checks++; if (q_count !== 3'd2 || mem_pc !== 32'h7) begin errors++; $display("FAIL halt_setup got cnt%0d pc%0h exp cnt2 pc7", q_count, mem_pc); end
    for (int j = 0; j < 5; j++) begin
      cyc();
      checks++; if (issue_valid === 1'b1 && issue_pc === 32'h7) begin errors++; $display("FAIL halt_issued got %0h exp not 7", issue_pc); end
      checks++; if (mem_pc !== 32'h7) begin errors++; $display("FAIL halt_mem_pc got %0h exp 7", mem_pc); end
      checks++; if (halted !== (j >= 1)) begin errors++; $display("FAIL halt_flag got %b exp %b", halted, j >= 1); end
    end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL halt_drained got %0d exp 0", q_count); end
  endtask

  task automatic test_redirect_halted();
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    cyc();
    redirect_valid = 1'b0;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL unhalt_flag got %b exp 0", halted); end
    checks++; if (mem_pc !== 32'h10) begin errors++; $display("FAIL unhalt_mem_pc got %0h exp 10", mem_pc); end
    cyc();
    checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h10) begin errors++; $display("FAIL unhalt_issue got v%b %0h exp v1 10", issue_valid, issue_pc); end
    checks++; if (mem_pc !== 32'h11) begin errors++; $display("FAIL unhalt_next_pc got %0h exp 11", mem_pc); end
    halt_pc = 32'h8000_0000;
  endtask

  task automatic test_full_pop_redirect();
    do_reset();
    for (int i = 0; i < 5; i++) cyc();
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL fpr_full got %0d exp 4", q_count); end
    issue_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h20;
    cyc();
    redirect_valid = 1'b0; issue_ready = 1'b0;
    checks++; if (q_count !== 3'd0 || issue_valid !== 1'b0) begin errors++; $display("FAIL fpr_flush got cnt%0d v%b exp cnt0 v0", q_count, issue_valid); end
    checks++; if (mem_pc !== 32'h20) begin errors++; $display("FAIL fpr_mem_pc got %0h exp 20", mem_pc); end
    cyc();
    checks++; if (q_count !== 3'd1 || issue_pc !== 32'h20) begin errors++; $display("FAIL fpr_refetch got cnt%0d pc%0h exp cnt1 pc20", q_count, issue_pc); end
  endtask

  task automatic test_reset_mid();
    cyc(); cyc();
    checks++; if (q_count !== 3'd3) begin errors++; $display("FAIL rstmid_pre got %0d exp 3", q_count); end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    checks++; if (mem_pc !== 32'h0 || q_count !== 3'd0) begin errors++; $display("FAIL rstmid_state got pc%0h cnt%0d exp pc0 cnt0", mem_pc, q_count); end
    checks++; if (issue_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rstmid_flags got v%b h%b exp v0 h0", issue_valid, halted); end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; issue_ready = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      e = 32'hFFFF_FFFE + 32'(i);
      checks++; if (issue_pc !== e) begin errors++; $display("FAIL wrap_issue got %0h exp %0h", issue_pc, e); end
      checks++; if (mem_pc !== e + 32'h1) begin errors++; $display("FAIL wrap_mem_pc got %0h exp %0h", mem_pc, e + 32'h1); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    halt_pc = 32'd25;
    for (int i = 0; i < 300; i++) begin
      issue_ready = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 19) == 0;
      redirect_pc = 32'($urandom_range(0, 40));
      cyc();
      checks++; if (q_count !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_count got %0d exp %0d", q_count, m_q.size()); end
      checks++; if (mem_pc !== m_pc) begin errors++; $display("FAIL rnd_mem_pc got %0h exp %0h", mem_pc, m_pc); end
      checks++; if (halted !== (m_st == 2)) begin errors++; $display("FAIL rnd_halted got %b exp %b", halted, m_st == 2); end
      checks++; if (issue_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid got %b exp %b", issue_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        checks++; if ({issue_pc, issue_instr} !== m_q[0]) begin errors++; $display("FAIL rnd_head got %0h:%0h exp %0h:%0h", issue_pc, issue_instr, m_q[0][63:32], m_q[0][31:0]); end
      end
    end
    redirect_valid = 1'b0;
    halt_pc = 32'h8000_0000;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_redirect_halted();
    test_full_pop_redirect();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
